// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx -- PS/2 device-to-host scancode receiver.
//
// Purpose:
//   Receives 11-bit PS/2 frames: start 0, eight data bits LSB first, odd parity, stop 1.
//   Both raw lines are synchronized into clk. The PS/2 clock is then debounced by a
//   run-length filter. Each filtered 1->0 transition samples the data line.
//   A completed valid frame updates rx_scan_code and pulses interrupt for one cycle.
//   A bad start bit, stop bit or parity bit, or an inter-edge timeout, pulses frame_err
//   for one cycle.
//
// Parameters:
//   FILTER_LEN      consecutive equal samples needed to flip the filtered clock (2..16)
//   TIMEOUT_CYCLES  clk cycles without a falling edge before a partial frame is dropped
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   ps2_clk       raw PS/2 clock line (asynchronous)
//   ps2_data      raw PS/2 data line (asynchronous)
//   interrupt     one-cycle pulse: new valid byte on rx_scan_code
//   rx_scan_code  last valid byte, held until the next valid byte
//   frame_err     one-cycle pulse: framing/parity error or timeout
//
// Configuration:
//   PS2_PARITY_CHECK_EN  when defined, a parity mismatch invalidates the frame.
//                        When undefined, the parity bit is captured but ignored.

module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 56000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       interrupt,
  output logic [7:0] rx_scan_code,
  output logic       frame_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizers. They reset to 1 because an idle PS/2 line is high.
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_s;
  logic       data_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // ---------------------------------------------------------------------------
  // Clock filter. The history holds the last FILTER_LEN synchronized samples.
  // The filtered clock only flips once the whole history agrees.
  // ---------------------------------------------------------------------------
  logic [FILTER_LEN-1:0] hist_q;
  logic [FILTER_LEN-1:0] hist_d;
  logic                  filt_q;
  logic                  filt_d;
  logic                  all_low;
  logic                  all_high;
  logic                  fall;

  always_comb begin
    hist_d   = {hist_q[FILTER_LEN-2:0], clk_s};
    all_low  = (hist_q == '0);
    all_high = &hist_q;
    filt_d   = filt_q;
    if (all_low) begin
      filt_d = 1'b0;
    end else if (all_high) begin
      filt_d = 1'b1;
    end
  end

  // The fall event is asserted in the cycle in which filt_q is about to drop.
  // data_s is sampled in that same cycle.
  assign fall = filt_q & all_low;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e          state_q;
  state_e          state_d;
  logic [2:0]      bit_cnt_q;
  logic [2:0]      bit_cnt_d;
  logic [7:0]      shift_q;
  logic [7:0]      shift_d;
  logic            parity_q;
  logic            parity_d;
  logic [7:0]      code_d;
  logic            irq_d;
  logic            err_d;
  logic [TmoW-1:0] tmo_q;
  logic [TmoW-1:0] tmo_d;
  logic            timeout;
  logic            frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity: the nine bits (data plus parity) must hold an odd number of ones.
  assign frame_ok = data_s & (^{shift_q, parity_q});
`else
  logic unused_parity;
  assign unused_parity = parity_q;
  assign frame_ok      = data_s;
`endif

  // The counter is always 0 in StIdle, so a timeout can only occur mid-frame.
  assign timeout = (tmo_q == TmoW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    code_d    = rx_scan_code;
    irq_d     = 1'b0;
    err_d     = 1'b0;
    tmo_d     = tmo_q;

    if (timeout) begin
      // A timeout beats a coincident fall event. That edge is dropped.
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      shift_d   = 8'h00;
      err_d     = 1'b1;
      tmo_d     = '0;
    end else begin
      if (state_q == StIdle || fall) begin
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end

      if (fall) begin
        case (state_q)
          StIdle: begin
            if (!data_s) begin
              state_d   = StData;
              bit_cnt_d = 3'd0;
              shift_d   = 8'h00;
            end else begin
              err_d = 1'b1;
            end
          end
          StData: begin
            shift_d   = {data_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = StParity;
            end
          end
          StParity: begin
            parity_d = data_s;
            state_d  = StStop;
          end
          StStop: begin
            state_d = StIdle;
            if (frame_ok) begin
              irq_d  = 1'b1;
              code_d = shift_q;
            end else begin
              err_d = 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      rx_scan_code <= 8'h00;
      interrupt    <= 1'b0;
      frame_err    <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      rx_scan_code <= code_d;
      interrupt    <= irq_d;
      frame_err    <= err_d;
      tmo_q        <= tmo_d;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

  localparam int unsigned FiltLen = 8;
  localparam int unsigned Tmo     = 300;
  localparam int unsigned Half    = 40;  // PS/2 half period in clk cycles

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       interrupt;
  logic [7:0] rx_scan_code;
  logic       frame_err;

  ps2_scancode_rx #(
    .FILTER_LEN    (FiltLen),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .interrupt   (interrupt),
    .rx_scan_code(rx_scan_code),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Protocol monitor. It samples on the falling edge, away from the DUT's updates.
  int         irq_cnt = 0;
  int         err_cnt = 0;
  int         overlap_cnt = 0;
  int         wide_cnt = 0;
  int         bad_change_cnt = 0;
  logic [7:0] codes[$];
  logic       irq_prev = 1'b0;
  logic       err_prev = 1'b0;
  logic [7:0] code_prev = 8'h00;

  always @(negedge clk) begin
    if (interrupt) begin
      irq_cnt++;
      codes.push_back(rx_scan_code);
    end
    if (frame_err) err_cnt++;
    if (interrupt && frame_err) overlap_cnt++;
    if ((interrupt && irq_prev) || (frame_err && err_prev)) wide_cnt++;
    if (!reset && rx_scan_code != code_prev && !interrupt) bad_change_cnt++;
    irq_prev  = interrupt;
    err_prev  = frame_err;
    code_prev = rx_scan_code;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data is set while the clock is high, then the clock goes low.
  // Optionally a 3-cycle low glitch is injected into the high phase.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cycles(20);
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
      wait_cycles(Half - 23);
    end else begin
      wait_cycles(Half);
    end
    ps2_clk = 1'b0;
    wait_cycles(Half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input bit glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch);
    ps2_bit(p, glitch);
    ps2_bit(1'b1, glitch);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ib;
  int eb;

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(5);
    check_eq("reset_irq", {31'd0, interrupt}, 32'd0);
    check_eq("reset_err", {31'd0, frame_err}, 32'd0);
    check_eq("reset_code", {24'd0, rx_scan_code}, 32'h00);
    reset = 1'b0;
    wait_cycles(20);
    check_eq("release_quiet", irq_cnt + err_cnt, 0);

    // Single frame 0x1C, parity 0
    ib = irq_cnt; eb = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_cycles(20);
    check_eq("1c_irq", irq_cnt - ib, 1);
    check_eq("1c_err", err_cnt - eb, 0);
    check_eq("1c_code", {24'd0, rx_scan_code}, 32'h1C);

    // Back-to-back 0xF0 (parity 1) then 0x1C (parity 0)
    ib = irq_cnt; eb = err_cnt;
    codes.delete();
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_cycles(20);
    check_eq("b2b_irq", irq_cnt - ib, 2);
    check_eq("b2b_err", err_cnt - eb, 0);
    if (codes.size() == 2) begin
      check_eq("b2b_code0", {24'd0, codes[0]}, 32'hF0);
      check_eq("b2b_code1", {24'd0, codes[1]}, 32'h1C);
    end else begin
      check_eq("b2b_codes_len", codes.size(), 2);
    end

    // Bad start bit: a falling edge with data high while idle
    ib = irq_cnt; eb = err_cnt;
    ps2_bit(1'b1, 1'b0);
    wait_cycles(Half);
    check_eq("start_err", err_cnt - eb, 1);
    check_eq("start_irq", irq_cnt - ib, 0);
    check_eq("start_code", {24'd0, rx_scan_code}, 32'h1C);

    // Timeout after start plus 4 data bits
    ib = irq_cnt; eb = err_cnt;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_cycles(Tmo + 60);
    check_eq("tmo_err", err_cnt - eb, 1);
    check_eq("tmo_irq", irq_cnt - ib, 0);
    ib = irq_cnt; eb = err_cnt;
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_cycles(20);
    check_eq("5a_irq", irq_cnt - ib, 1);
    check_eq("5a_err", err_cnt - eb, 0);
    check_eq("5a_code", {24'd0, rx_scan_code}, 32'h5A);

    // 0x1C with wrong parity bit 1
    ib = irq_cnt; eb = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    wait_cycles(20);
`ifdef PS2_PARITY_CHECK_EN
    check_eq("par_err", err_cnt - eb, 1);
    check_eq("par_irq", irq_cnt - ib, 0);
    check_eq("par_code", {24'd0, rx_scan_code}, 32'h5A);
`else
    check_eq("par_err", err_cnt - eb, 0);
    check_eq("par_irq", irq_cnt - ib, 1);
    check_eq("par_code", {24'd0, rx_scan_code}, 32'h1C);
`endif

    // 0x29 (parity 0) with short low glitches in every high phase
    ib = irq_cnt; eb = err_cnt;
    send_frame(8'h29, 1'b0, 1'b1);
    wait_cycles(20);
    check_eq("glitch_irq", irq_cnt - ib, 1);
    check_eq("glitch_err", err_cnt - eb, 0);
    check_eq("glitch_code", {24'd0, rx_scan_code}, 32'h29);

    // Reset after the 5th data bit, then 0x12 (parity 1)
    ib = irq_cnt; eb = err_cnt;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0], 1'b0);
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(10);
    check_eq("rst_mid_code", {24'd0, rx_scan_code}, 32'h00);
    reset = 1'b0;
    wait_cycles(Tmo + 60);
    check_eq("rst_mid_irq", irq_cnt - ib, 0);
    check_eq("rst_mid_err", err_cnt - eb, 0);
    send_frame(8'h12, 1'b1, 1'b0);
    wait_cycles(20);
    check_eq("12_irq", irq_cnt - ib, 1);
    check_eq("12_err", err_cnt - eb, 0);
    check_eq("12_code", {24'd0, rx_scan_code}, 32'h12);

    // Pulse hygiene over the whole run
    check_eq("overlap", overlap_cnt, 0);
    check_eq("pulse_width", wide_cnt, 0);
    check_eq("code_stable", bad_change_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
